// File: rtl/axum_xbar.sv
// Shared bus crossbar: round-robin host arbitration, mask/base device decode,
// decode-error and timeout responses, with quarantine of devices that answer late.
module axum_xbar #(
  parameter int unsigned NrHosts       = 2,
  parameter int unsigned NrDevices     = 3,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [DataWidth-1:0]              host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,
  output logic [NrDevices-1:0]              device_req_o,
  output logic [AddressWidth-1:0]           device_addr_o,
  output logic                              device_we_o,
  output logic [DataWidth/8-1:0]            device_be_o,
  output logic [DataWidth-1:0]              device_wdata_o,
  input  logic [NrDevices-1:0]              device_rvalid_i,
  input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]              device_err_i,
  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned CntW     = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  state_e               state_q, state_d;
  logic [HostIdxW-1:0]  rr_ptr_q, rr_ptr_d, host_q, host_d;
  logic [DevIdxW-1:0]   dev_q, dev_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NrDevices-1:0] stale_q, stale_d;

  logic [AddressWidth-1:0] h_addr  [NrHosts];
  logic [BeWidth-1:0]      h_be    [NrHosts];
  logic [DataWidth-1:0]    h_wdata [NrHosts];
  logic [DataWidth-1:0]    d_rdata [NrDevices];
  logic [AddressWidth-1:0] d_base  [NrDevices];
  logic [AddressWidth-1:0] d_mask  [NrDevices];

  for (genvar h = 0; h < NrHosts; h++) begin : g_host
    assign h_addr[h]  = host_addr_i[h*AddressWidth +: AddressWidth];
    assign h_be[h]    = host_be_i[h*BeWidth +: BeWidth];
    assign h_wdata[h] = host_wdata_i[h*DataWidth +: DataWidth];
  end

  for (genvar d = 0; d < NrDevices; d++) begin : g_dev
    assign d_rdata[d] = device_rdata_i[d*DataWidth +: DataWidth];
    assign d_base[d]  = cfg_device_addr_base_i[d*AddressWidth +: AddressWidth];
    assign d_mask[d]  = cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth];
  end

  // Round-robin scan starting at rr_ptr_q.
  logic                arb_valid;
  logic [HostIdxW-1:0] arb_idx, scan_idx;

  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      scan_idx = HostIdxW'((32'(rr_ptr_q) + i) % NrHosts);
      if (!arb_valid && host_req_i[scan_idx]) begin
        arb_valid = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  // Lowest-index non-quarantined match wins.
  logic                    dec_hit;
  logic [DevIdxW-1:0]      dec_idx;
  logic [AddressWidth-1:0] win_addr;

  assign win_addr = h_addr[arb_idx];

  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dec_hit && !stale_q[d] && ((win_addr & d_mask[d]) == d_base[d])) begin
        dec_hit = 1'b1;
        dec_idx = DevIdxW'(d);
      end
    end
  end

  logic resp_done, timeout, arb_en;

  assign resp_done = (state_q == StWait) && device_rvalid_i[dev_q];
  assign timeout   = (state_q == StWait) && !resp_done && (cnt_q == CntW'(TimeoutCycles - 1));
  assign arb_en    = (state_q == StIdle) || resp_done;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    host_d   = host_q;
    dev_d    = dev_q;
    cnt_d    = cnt_q;
    stale_d  = stale_q;

    host_gnt_o     = '0;
    host_rvalid_o  = '0;
    host_rdata_o   = '0;
    host_err_o     = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = 1'b0;
    device_be_o    = '0;
    device_wdata_o = '0;

    unique case (state_q)
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (resp_done) begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q]    = device_err_i[dev_q];
          host_rdata_o          = d_rdata[dev_q];
          cnt_d                 = '0;
          state_d               = StIdle;
        end else if (timeout) begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q]    = 1'b1;
          stale_d[dev_q]        = 1'b1;
          cnt_d                 = '0;
          state_d               = StIdle;
        end
      end
      StErr: begin
        host_rvalid_o[host_q] = 1'b1;
        host_err_o[host_q]    = 1'b1;
        state_d               = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A late answer from a quarantined device lifts the quarantine and is dropped.
    for (int unsigned x = 0; x < NrDevices; x++) begin
      if (device_rvalid_i[x] && stale_q[x] && !(state_q == StWait && 32'(dev_q) == x)) begin
        stale_d[x] = 1'b0;
      end
    end

    if (arb_en && arb_valid) begin
      host_gnt_o[arb_idx] = 1'b1;
      host_d              = arb_idx;
      rr_ptr_d            = HostIdxW'((32'(arb_idx) + 32'd1) % NrHosts);
      cnt_d               = '0;
      if (dec_hit) begin
        device_req_o[dec_idx] = 1'b1;
        device_addr_o         = win_addr;
        device_we_o           = host_we_i[arb_idx];
        device_be_o           = h_be[arb_idx];
        device_wdata_o        = h_wdata[arb_idx];
        dev_d                 = dec_idx;
        state_d               = StWait;
      end else begin
        state_d = StErr;
      end
    end

    // Nothing is granted or answered while reset is held.
    if (rst_i) begin
      host_gnt_o     = '0;
      host_rvalid_o  = '0;
      host_rdata_o   = '0;
      host_err_o     = '0;
      device_req_o   = '0;
      device_addr_o  = '0;
      device_we_o    = 1'b0;
      device_be_o    = '0;
      device_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      host_q   <= '0;
      dev_q    <= '0;
      cnt_q    <= '0;
      stale_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      host_q   <= host_d;
      dev_q    <= dev_d;
      cnt_q    <= cnt_d;
      stale_q  <= stale_d;
    end
  end

endmodule

// File: doc/axum_xbar.md
Name: axum_xbar

Overview:
- Parametrised multi-host, multi-device shared bus that replaces the fixed single-host bus in the axum SoC top.
- Adds round-robin arbitration across NrHosts (core data, debug, DMA), address decode over NrDevices, and a decode-error response for unmapped addresses.
- Adds a response timeout, with quarantine of a device that answers late.
- One transaction outstanding at a time; devices use the codebase req/we/be/addr/wdata to rvalid/rdata/err protocol with no device-side grant.

Parameters:
NrHosts, 2, number of host ports (≥1)
NrDevices, 3, number of device ports (≥1)
DataWidth, 32, data bus width
AddressWidth, 32, address bus width
TimeoutCycles, 16, cycles in WAIT before a timeout error (≥2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
host_req_i  in  NrHosts  per-host request
host_gnt_o  out  NrHosts  per-host grant, one-hot or zero
host_addr_i  in  NrHosts*AddressWidth  packed host addresses, host h at [h*AW +: AW]
host_we_i  in  NrHosts  write enable
host_be_i  in  NrHosts*DataWidth/8  byte enables
host_wdata_i  in  NrHosts*DataWidth  write data
host_rvalid_o  out  NrHosts  response valid
host_rdata_o  out  DataWidth  read data, shared by all hosts, qualified by host_rvalid_o
host_err_o  out  NrHosts  response error
device_req_o  out  NrDevices  per-device request
device_addr_o  out  AddressWidth  shared address
device_we_o  out  1  shared write enable
device_be_o  out  DataWidth/8  shared byte enables
device_wdata_o  out  DataWidth  shared write data
device_rvalid_i  in  NrDevices  device response valid
device_rdata_i  in  NrDevices*DataWidth  packed device read data
device_err_i  in  NrDevices  device error
cfg_device_addr_base_i  in  NrDevices*AddressWidth  packed base addresses
cfg_device_addr_mask_i  in  NrDevices*AddressWidth  packed masks

Behaviour:

Reset (rst_i sampled high on a clk_i edge):
- state=IDLE, rr_ptr=0, timeout counter=0, all stale bits=0.
- All outputs 0 while state is IDLE and no host_req_i is asserted.

Reset mid-operation:
- Any WAIT or ERR state aborts without a host response.
- Stale bits clear.
- Device rvalids arriving after reset are ignored.

Decode:
- Device d matches when (addr & mask_d) == base_d and stale_d == 0.
- The lowest-index match wins.
- No match means decode miss.

Arbitration cycle (state IDLE, or the WAIT cycle in which the response completes):
- Winner is the first requesting host scanning rr_ptr, rr_ptr+1, ... mod NrHosts.
- Same cycle, combinational: host_gnt_o[winner]=1.
- On a hit, same cycle: device_req_o[d]=1, and the winner's addr/we/be/wdata drive the shared device signals.
- Register winner and d; rr_ptr <= (winner+1) mod NrHosts.
- Next state: WAIT on a hit, ERR on a miss.
- On a miss: no device_req_o.
- A host whose request is not granted holds its request.

ERR (1 cycle):
- host_rvalid_o[winner]=1, host_err_o[winner]=1, host_rdata_o=0.
- Next state IDLE; no grant is issued in ERR.

WAIT:
- The counter increments each cycle in WAIT.
- When device_rvalid_i[d]=1, same cycle:
  - host_rvalid_o[winner]=1, host_rdata_o=device_rdata_i[d], host_err_o[winner]=device_err_i[d].
  - The counter clears.
  - A new arbitration occurs this cycle (back-to-back support).
- With a 1-cycle device, throughput is one transaction per cycle.
- When the counter reaches TimeoutCycles-1 without rvalid:
  - host_rvalid_o[winner]=1, host_err_o[winner]=1, rdata=0.
  - stale_d <= 1; next state IDLE; no grant this cycle.

Rvalid handling:
- device_rvalid_i[x] outside its own WAIT, with stale_x=1, clears stale_x and is not forwarded.
- With stale_x=0 it is ignored.
- An rvalid on the cycle a timeout fires is treated as a normal response; the timeout does not fire.

Addresses are compared at the full AddressWidth; there is no wrap-around.

Test Plan:
- Reset, then host0 reads 0x100004 (RAM base 0x100000, mask ~0x1FFF) with rvalid 1 cycle later, rdata 0xDEADBEEF -> gnt[0] in cycle 0, device_req_o[0] in cycle 0; rvalid[0], rdata 0xDEADBEEF, err 0 in cycle 1.
- Hosts 0 and 1 request continuously to RAM (1-cycle device) -> grants alternate 0,1,0,1 on consecutive cycles; no idle cycles.
- Host1 accesses 0x40000 (unmapped) -> gnt[1], no device_req_o; next cycle rvalid[1]=1, err[1]=1, rdata=0.
- Timer never responds, TimeoutCycles=16 -> rvalid+err to the host 16 cycles after grant; a later access to the timer gets a decode error until the timer pulses rvalid; the access after that reaches the timer.
- Device asserts rvalid with err=1 -> host_err_o asserted for the winner only.
- Assert rst_i during WAIT -> next cycle all outputs 0, no response delivered, rr_ptr=0.
